// File: rtl/shift_pkg.sv
// shift_pkg: shared types and defaults for the bit-shift serial link.
package shift_pkg;
   typedef enum logic {DIR_MSB_FIRST = 1'b0, DIR_LSB_FIRST = 1'b1} shift_dir_e;
   typedef enum logic {ST_DATA, ST_PARITY} deser_state_e;
   localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/shift_in_reg.sv
// shift_in_reg: WIDTH-bit shift-in register, left (MSB first) or right (LSB first).
// o_word is the value the word holds after this edge: shifted when i_en, else current.
module shift_in_reg
   import shift_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             i_en,
   input  logic             i_clr,
   input  shift_dir_e       i_dir,
   input  logic             i_sin,
   output logic [WIDTH-1:0] o_word
);
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;
   assign w_next = (i_dir == DIR_LSB_FIRST) ? {i_sin, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], i_sin};
   assign o_word = i_en ? w_next : r_q;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_q <= '0;
      else if (i_clr) r_q <= '0;
      else if (i_en) r_q <= w_next;
   end
endmodule

// File: rtl/shift_deserializer.sv
// shift_deserializer: rebuilds WIDTH-bit words from a serial bit stream into a one-entry valid/ready buffer.
// Define DESER_PARITY_EN to expect an even-parity bit after each word and report it on m_perr.
module shift_deserializer
   import shift_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             s_valid,
   input  logic             s_data,
   output logic             s_ready,
   input  logic             dir,
   input  logic             clear,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready
`ifdef DESER_PARITY_EN
   ,
   output logic             m_perr
`endif
);
   localparam int CW = $clog2(WIDTH);
   logic [CW-1:0]    r_cnt;
   shift_dir_e       r_dir;
   shift_dir_e       w_dir;
   logic             r_m_valid;
   logic [WIDTH-1:0] r_m_data;
   logic [WIDTH-1:0] w_word;
   logic             w_last_data;
   logic             w_last;
   logic             w_acc;
   logic             w_done;
   logic             w_shift;
   assign w_last_data = r_cnt == CW'(WIDTH - 1);
   // direction is sampled live on the first bit, then held for the rest of the word
   assign w_dir = (r_cnt == '0) ? shift_dir_e'(dir) : r_dir;
`ifdef DESER_PARITY_EN
   deser_state_e r_state;
   logic         r_m_perr;
   assign w_last  = r_state == ST_PARITY;
   assign w_shift = w_acc && r_state == ST_DATA;
   assign m_perr  = r_m_perr;
`else
   assign w_last  = w_last_data;
   assign w_shift = w_acc;
`endif
   assign s_ready = !clear && !(w_last && r_m_valid && !m_ready);
   assign w_acc   = s_valid && s_ready;
   assign w_done  = w_acc && w_last;
   assign m_valid = r_m_valid;
   assign m_data  = r_m_data;
   shift_in_reg #(.WIDTH(WIDTH)) u_sr (
      .clk   (clk),
      .nrst  (nrst),
      .i_en  (w_shift),
      .i_clr (clear || w_done),
      .i_dir (w_dir),
      .i_sin (s_data),
      .o_word(w_word)
   );
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt     <= '0;
         r_dir     <= DIR_MSB_FIRST;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
`ifdef DESER_PARITY_EN
         r_state   <= ST_DATA;
         r_m_perr  <= 1'b0;
`endif
      end else begin
         if (clear) r_cnt <= '0;
         else if (w_shift) begin
            r_cnt <= w_last_data ? '0 : r_cnt + 1'b1;
            r_dir <= w_dir;
         end
`ifdef DESER_PARITY_EN
         if (clear) r_state <= ST_DATA;
         else if (w_acc) r_state <= (r_state == ST_DATA && w_last_data) ? ST_PARITY : ST_DATA;
`endif
         if (w_done) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_word;
`ifdef DESER_PARITY_EN
            r_m_perr  <= ^{w_word, s_data};
`endif
         end else if (m_ready) r_m_valid <= 1'b0;
      end
   end
endmodule
